conv_transpose2d: RTL and testbench
===================================

Name: conv_transpose2d

Overview:
Stride-upsampling transposed 2-D convolution (decoder-side counterpart of conv2d) for the HCVC-HEM datapath.
- Reads an NCHW input tensor through the same combinational-read memory port style as conv2d.
- Writes the upsampled NCHW output tensor through a registered write port.
- Weights are hardcoded to 1 and bias to 0, matching conv2d, so both directions can be verified against closed-form sums.

Parameters:
BATCH_SIZE, 1, batches processed per start
IN_CHANNELS, 1, input feature channels
OUT_CHANNELS, 2, output feature channels
IN_HEIGHT, 2, input rows
IN_WIDTH, 2, input columns
KERNEL_SIZE, 2, square kernel side K
STRIDE, 2, upsampling stride S
PADDING, 0, output crop P per side
DATA_WIDTH, 32, element width, two's complement
ADDR_WIDTH, 16, memory address width
Derived: OUT_HEIGHT = (IN_HEIGHT-1)*S - 2P + K; OUT_WIDTH likewise.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  begin job; sampled only in IDLE
done  out  1  one-cycle pulse when the job completes
valid  out  1  high in every cycle that an output write is issued
input_addr  out  ADDR_WIDTH  input read address
input_data  in  DATA_WIDTH  read data, combinational from input_addr/input_en
input_en  out  1  input read enable
output_addr  out  ADDR_WIDTH  output write address
output_data  out  DATA_WIDTH  output write data
output_we  out  1  write enable
output_en  out  1  output port enable; equals output_we

Behaviour:
- Reset (rst_n low, async): state=IDLE, every counter and the accumulator clear to 0, and all outputs are 0.
- Address map (NCHW): addr = ((b*C + c)*H + y)*W + x.
- Loop order, outermost first: b, oc, oy, ox, ic, ky, kx.
- Tap validity:
  - ty = oy + P - ky and tx = ox + P - kx.
  - A tap is valid iff ty >= 0, tx >= 0, ty%S == 0, tx%S == 0, ty/S < IN_HEIGHT and tx/S < IN_WIDTH.
  - Compute this with signed intermediates of sufficient width.
- IDLE: start=1 moves to ACC with acc=0 and all indices at 0. Otherwise the block stays in IDLE.
- ACC: one tap per cycle, exactly IN_CHANNELS*K*K cycles per output pixel; invalid taps are not skipped.
  - Valid tap: input_en=1, input_addr = addr(b, ic, ty/S, tx/S), acc += input_data on the clock edge.
  - Invalid tap: input_en=0, input_addr=0, acc unchanged.
  - After the last tap, go to WRITE.
- WRITE: one cycle.
  - output_we = output_en = valid = 1, output_addr = addr(b, oc, oy, ox), output_data = acc.
  - Then clear acc and advance ox, oy, oc, b.
  - If more pixels remain, go to ACC; otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH*(IN_CHANNELS*K*K + 1) + 1 cycles from the start edge to the done pulse.
- Arithmetic: signed DATA_WIDTH accumulation, wrap modulo 2^DATA_WIDTH, no saturation. Bias 0 is added, which is a no-op.
- start while busy (not IDLE) is ignored. start held high through DONE re-launches only after the block has returned to IDLE.
- Reset mid-job aborts at once. Writes already issued stay in memory, and no done pulse is produced.
- Degenerate geometry (OUT_HEIGHT or OUT_WIDTH < 1) is an elaboration error via a generate-time check.

Optional Feature:
CONV_TRANSPOSE_RELU_EN
- Defined: output_data in WRITE is 0 when acc is negative (MSB=1), otherwise acc.
- Undefined: acc is written unmodified.
- Timing and the cycle count are identical in both builds.

Decomposition:
- Shared package/header conv_pkg holds:
  - the out-size functions for both conv2d and conv_transpose2d;
  - the NCHW address function;
  - the FSM state encoding (IDLE, ACC, WRITE, DONE).
- Sub-module conv_t_tap_gen owns the ic/ky/kx counters and validity logic. It outputs tap_valid, the input address and last_tap, driven by an advance strobe from the top FSM.

Test Plan:
1. Defaults, input = 0..3 (2x2) → 32 writes. Each output channel equals the nearest-neighbour upsample [0,0,1,1; 0,0,1,1; 2,2,3,3; 2,2,3,3]. Expect done after 32*5 + 1 = 161 cycles and valid pulsed 32 times.
2. IN_CHANNELS=2, OUT_CHANNELS=1, input = 0..7 → 4x4 output of block values [4,6; 8,10], each replicated 2x2. This round-trips the conv2d dataflow in the opposite direction.
3. K=3, S=2, P=1, 1→1 channel, input all 1s (2x2) → 3x3 output [1,2,1; 2,4,2; 1,2,1], exercising overlap and crop validity.
4. Input containing -5 and +2 contributions to one pixel (sum -3):
   - With CONV_TRANSPOSE_RELU_EN: that output = 0.
   - Without it: output = 32'hFFFFFFFD.
5. Assert rst_n low mid-ACC of pixel 5 → all outputs 0 immediately and no done pulse. A restart then produces the full correct result of test 1.
6. start pulsed during ACC and held high across DONE → exactly one job per IDLE acceptance. Expect no extra writes and the second job starting only after IDLE is reached.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: types and helpers shared by the conv2d / conv_transpose2d datapaths.
// Contents: FSM state encoding, output-size functions for both directions,
//           and the NCHW linear address function.
package conv_pkg;

   // Width of every loop index counter (batch, channel, row, column, kernel).
   localparam int IDX_W = 16;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } conv_state_e;

   // Forward convolution output side.
   function automatic int conv2d_out_size(input int in_size, input int k,
                                          input int s, input int p);
      return (in_size + 2*p - k) / s + 1;
   endfunction

   // Transposed convolution output side.
   function automatic int conv_t_out_size(input int in_size, input int k,
                                          input int s, input int p);
      return (in_size - 1)*s - 2*p + k;
   endfunction

   // Linear address of element (b, c, y, x) in an NCHW tensor with n_c channels.
   function automatic int nchw_addr(input int b, input int c, input int y,
                                    input int x, input int n_c, input int h,
                                    input int w);
      return ((b*n_c + c)*h + y)*w + x;
   endfunction

endpackage

// File: rtl/conv_t_tap_gen.sv
// conv_t_tap_gen: walks the ic/ky/kx taps of one output pixel of a transposed conv.
// Ports: adv_i steps to the next tap; b_i/oy_i/ox_i select the output pixel;
//        tap_valid_o/tap_addr_o give the input element for the current tap; last_tap_o flags the final tap.
module conv_t_tap_gen
   import conv_pkg::*;
#(
   parameter int IN_CHANNELS = 1,
   parameter int IN_HEIGHT   = 2,
   parameter int IN_WIDTH    = 2,
   parameter int KERNEL_SIZE = 2,
   parameter int STRIDE      = 2,
   parameter int PADDING     = 0,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  adv_i,
   input  idx_t                  b_i,
   input  idx_t                  oy_i,
   input  idx_t                  ox_i,
   output logic                  tap_valid_o,
   output logic [ADDR_WIDTH-1:0] tap_addr_o,
   output logic                  last_tap_o
);

   // Two extra bits keep oy + P - ky representable and signed.
   localparam int SW = IDX_W + 2;
   localparam logic signed [SW-1:0] P_S = SW'(PADDING);
   localparam logic signed [SW-1:0] S_S = SW'(STRIDE);
   localparam logic signed [SW-1:0] H_S = SW'(IN_HEIGHT);
   localparam logic signed [SW-1:0] W_S = SW'(IN_WIDTH);

   idx_t ic_q, ic_d, ky_q, ky_d, kx_q, kx_d;
   logic last_ic, last_ky, last_kx;
   logic signed [SW-1:0] ty, tx, iy, ix;

   assign last_ic    = (ic_q == idx_t'(IN_CHANNELS-1));
   assign last_ky    = (ky_q == idx_t'(KERNEL_SIZE-1));
   assign last_kx    = (kx_q == idx_t'(KERNEL_SIZE-1));
   assign last_tap_o = last_ic && last_ky && last_kx;

   // Gather view: output (oy,ox) takes input (ty/S, tx/S) when ty, tx land on the stride grid.
   assign ty = $signed({2'b00, oy_i}) + P_S - $signed({2'b00, ky_q});
   assign tx = $signed({2'b00, ox_i}) + P_S - $signed({2'b00, kx_q});
   assign iy = ty / S_S;
   assign ix = tx / S_S;

   assign tap_valid_o = !ty[SW-1] && !tx[SW-1] &&
                        (ty % S_S == '0) && (tx % S_S == '0) &&
                        (iy < H_S) && (ix < W_S);

   assign tap_addr_o = tap_valid_o ?
      ADDR_WIDTH'(nchw_addr(int'(b_i), int'(ic_q), int'(iy), int'(ix),
                            IN_CHANNELS, IN_HEIGHT, IN_WIDTH)) : '0;

   // kx fastest, then ky, then ic; all wrap to 0 after the last tap.
   always_comb begin
      ic_d = ic_q;
      ky_d = ky_q;
      kx_d = kx_q;
      if (adv_i) begin
         if (!last_kx) begin
            kx_d = kx_q + idx_t'(1);
         end else begin
            kx_d = '0;
            if (!last_ky) begin
               ky_d = ky_q + idx_t'(1);
            end else begin
               ky_d = '0;
               ic_d = last_ic ? '0 : ic_q + idx_t'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ic_q <= '0;
         ky_q <= '0;
         kx_q <= '0;
      end else begin
         ic_q <= ic_d;
         ky_q <= ky_d;
         kx_q <= kx_d;
      end
   end

endmodule

// File: rtl/conv_transpose2d.sv
// conv_transpose2d: stride-upsampling transposed 2-D conv, weights 1, bias 0, NCHW in/out.
// Ports: start/done handshake, combinational-read input port, write port (output_*), valid per write.
// Build option CONV_TRANSPOSE_RELU_EN clamps negative results to 0 on write; timing unchanged.
module conv_transpose2d
   import conv_pkg::*;
#(
   parameter int BATCH_SIZE   = 1,
   parameter int IN_CHANNELS  = 1,
   parameter int OUT_CHANNELS = 2,
   parameter int IN_HEIGHT    = 2,
   parameter int IN_WIDTH     = 2,
   parameter int KERNEL_SIZE  = 2,
   parameter int STRIDE       = 2,
   parameter int PADDING      = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  done,
   output logic                  valid,
   output logic [ADDR_WIDTH-1:0] input_addr,
   input  logic [DATA_WIDTH-1:0] input_data,
   output logic                  input_en,
   output logic [ADDR_WIDTH-1:0] output_addr,
   output logic [DATA_WIDTH-1:0] output_data,
   output logic                  output_we,
   output logic                  output_en
);

   localparam int OUT_HEIGHT = conv_t_out_size(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING);
   localparam int OUT_WIDTH  = conv_t_out_size(IN_WIDTH,  KERNEL_SIZE, STRIDE, PADDING);

   generate
      if (OUT_HEIGHT < 1 || OUT_WIDTH < 1) begin : g_bad_geometry
         $error("conv_transpose2d: output geometry is empty");
      end
   endgenerate

   conv_state_e state_q, state_d;
   idx_t b_q, b_d, oc_q, oc_d, oy_q, oy_d, ox_q, ox_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d, wr_data;
   logic [ADDR_WIDTH-1:0] tap_addr;
   logic tap_adv, tap_valid, last_tap;
   logic last_b, last_oc, last_oy, last_ox;

   assign last_b  = (b_q  == idx_t'(BATCH_SIZE-1));
   assign last_oc = (oc_q == idx_t'(OUT_CHANNELS-1));
   assign last_oy = (oy_q == idx_t'(OUT_HEIGHT-1));
   assign last_ox = (ox_q == idx_t'(OUT_WIDTH-1));

`ifdef CONV_TRANSPOSE_RELU_EN
   assign wr_data = acc_q[DATA_WIDTH-1] ? '0 : acc_q;
`else
   assign wr_data = acc_q;
`endif

   conv_t_tap_gen #(
      .IN_CHANNELS (IN_CHANNELS),
      .IN_HEIGHT   (IN_HEIGHT),
      .IN_WIDTH    (IN_WIDTH),
      .KERNEL_SIZE (KERNEL_SIZE),
      .STRIDE      (STRIDE),
      .PADDING     (PADDING),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_tap_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .adv_i       (tap_adv),
      .b_i         (b_q),
      .oy_i        (oy_q),
      .ox_i        (ox_q),
      .tap_valid_o (tap_valid),
      .tap_addr_o  (tap_addr),
      .last_tap_o  (last_tap)
   );

   always_comb begin
      state_d     = state_q;
      b_d         = b_q;
      oc_d        = oc_q;
      oy_d        = oy_q;
      ox_d        = ox_q;
      acc_d       = acc_q;
      tap_adv     = 1'b0;
      done        = 1'b0;
      valid       = 1'b0;
      input_en    = 1'b0;
      input_addr  = '0;
      output_addr = '0;
      output_data = '0;
      output_we   = 1'b0;
      output_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACC;
               acc_d   = '0;
               b_d     = '0;
               oc_d    = '0;
               oy_d    = '0;
               ox_d    = '0;
            end
         end
         ST_ACC: begin
            // Invalid taps still take their cycle so per-pixel time is fixed.
            tap_adv = 1'b1;
            if (tap_valid) begin
               input_en   = 1'b1;
               input_addr = tap_addr;
               acc_d      = acc_q + input_data;
            end
            if (last_tap) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            valid       = 1'b1;
            output_we   = 1'b1;
            output_en   = 1'b1;
            output_addr = ADDR_WIDTH'(nchw_addr(int'(b_q), int'(oc_q), int'(oy_q),
                                                int'(ox_q), OUT_CHANNELS,
                                                OUT_HEIGHT, OUT_WIDTH));
            output_data = wr_data;
            acc_d       = '0;
            if (!last_ox) begin
               ox_d = ox_q + idx_t'(1);
            end else begin
               ox_d = '0;
               if (!last_oy) begin
                  oy_d = oy_q + idx_t'(1);
               end else begin
                  oy_d = '0;
                  if (!last_oc) begin
                     oc_d = oc_q + idx_t'(1);
                  end else begin
                     oc_d = '0;
                     b_d  = last_b ? '0 : b_q + idx_t'(1);
                  end
               end
            end
            state_d = (last_b && last_oc && last_oy && last_ox) ? ST_DONE : ST_ACC;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         b_q     <= '0;
         oc_q    <= '0;
         oy_q    <= '0;
         ox_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         oc_q    <= oc_d;
         oy_q    <= oy_d;
         ox_q    <= ox_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: tb/tb_conv_transpose2d.sv
// tb_conv_transpose2d: scoreboard bench for conv_transpose2d.
// Two instances: A uses the default geometry, B uses batch 2, 2->1 channels, 3x2 input, K3 S2 P1.
// Expected writes come from a scatter-form reference model and are checked by per-instance monitors.
module tb_conv_transpose2d;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int A_N = 1, A_IC = 1, A_OC = 2, A_H = 2, A_W = 2, A_K = 2, A_S = 2, A_P = 0;
   localparam int B_N = 2, B_IC = 2, B_OC = 1, B_H = 3, B_W = 2, B_K = 3, B_S = 2, B_P = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic start_a, done_a, valid_a, in_en_a, out_we_a, out_en_a;
   logic [AW-1:0] in_addr_a, out_addr_a;
   logic [DW-1:0] in_data_a, out_data_a;
   logic start_b, done_b, valid_b, in_en_b, out_we_b, out_en_b;
   logic [AW-1:0] in_addr_b, out_addr_b;
   logic [DW-1:0] in_data_b, out_data_b;

   logic [DW-1:0] mem_a [0:255];
   logic [DW-1:0] mem_b [0:255];
   logic [DW-1:0] obs_a [0:255];
   logic [DW-1:0] obs_b [0:255];

   // Disabled reads return garbage so a tap that adds without enabling is visible.
   assign in_data_a = in_en_a ? mem_a[in_addr_a[7:0]] : 32'hDEAD_BEEF;
   assign in_data_b = in_en_b ? mem_b[in_addr_b[7:0]] : 32'hDEAD_BEEF;

   conv_transpose2d #(
      .BATCH_SIZE(A_N), .IN_CHANNELS(A_IC), .OUT_CHANNELS(A_OC), .IN_HEIGHT(A_H),
      .IN_WIDTH(A_W), .KERNEL_SIZE(A_K), .STRIDE(A_S), .PADDING(A_P),
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .done(done_a), .valid(valid_a),
      .input_addr(in_addr_a), .input_data(in_data_a), .input_en(in_en_a),
      .output_addr(out_addr_a), .output_data(out_data_a), .output_we(out_we_a),
      .output_en(out_en_a)
   );

   conv_transpose2d #(
      .BATCH_SIZE(B_N), .IN_CHANNELS(B_IC), .OUT_CHANNELS(B_OC), .IN_HEIGHT(B_H),
      .IN_WIDTH(B_W), .KERNEL_SIZE(B_K), .STRIDE(B_S), .PADDING(B_P),
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .done(done_b), .valid(valid_b),
      .input_addr(in_addr_b), .input_data(in_data_b), .input_en(in_en_b),
      .output_addr(out_addr_b), .output_data(out_data_b), .output_we(out_we_b),
      .output_en(out_en_b)
   );

   logic [AW-1:0] qa_addr[$], qb_addr[$];
   logic [DW-1:0] qa_data[$], qb_data[$];
   int wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
   int n_checks = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Scatter model: every input element adds into each output it reaches through the kernel.
   task automatic build_exp(input int d);
      int nb, ci, co, h, w, k, s, p, oh, ow, oy, ox, total;
      logic [DW-1:0] o [0:255];
      logic [DW-1:0] v, r;
      if (d == 0) begin
         nb = A_N; ci = A_IC; co = A_OC; h = A_H; w = A_W; k = A_K; s = A_S; p = A_P;
      end else begin
         nb = B_N; ci = B_IC; co = B_OC; h = B_H; w = B_W; k = B_K; s = B_S; p = B_P;
      end
      oh = (h - 1)*s - 2*p + k;
      ow = (w - 1)*s - 2*p + k;
      for (int i = 0; i < 256; i++) o[i] = '0;
      for (int b = 0; b < nb; b++)
         for (int c = 0; c < ci; c++)
            for (int iy = 0; iy < h; iy++)
               for (int ix = 0; ix < w; ix++) begin
                  v = (d == 0) ? mem_a[((b*ci + c)*h + iy)*w + ix]
                               : mem_b[((b*ci + c)*h + iy)*w + ix];
                  for (int q = 0; q < co; q++)
                     for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                           oy = iy*s - p + ky;
                           ox = ix*s - p + kx;
                           if (oy >= 0 && oy < oh && ox >= 0 && ox < ow)
                              o[((b*co + q)*oh + oy)*ow + ox] += v;
                        end
               end
      total = nb*co*oh*ow;
      // Write order b, oc, oy, ox is exactly ascending NCHW address.
      for (int n = 0; n < total; n++) begin
         r = o[n];
`ifdef CONV_TRANSPOSE_RELU_EN
         if (r[DW-1]) r = '0;
`endif
         if (d == 0) begin qa_addr.push_back(AW'(n)); qa_data.push_back(r); end
         else        begin qb_addr.push_back(AW'(n)); qb_data.push_back(r); end
      end
   endtask

   function automatic int exp_writes(input int d);
      if (d == 0) return A_N*A_OC*((A_H-1)*A_S - 2*A_P + A_K)*((A_W-1)*A_S - 2*A_P + A_K);
      return B_N*B_OC*((B_H-1)*B_S - 2*B_P + B_K)*((B_W-1)*B_S - 2*B_P + B_K);
   endfunction

   function automatic logic get_done(input int d);
      return (d == 0) ? done_a : done_b;
   endfunction

   task automatic set_start(input int d, input logic v);
      if (d == 0) start_a = v; else start_b = v;
   endtask

   // Monitors: pop the scoreboard on every issued write.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_a || out_we_a || out_en_a)
            chk("a_we_en_vs_valid", {out_we_a, out_en_a}, {valid_a, valid_a});
         if (valid_a) begin
            wr_cnt_a++;
            obs_a[out_addr_a[7:0]] = out_data_a;
            chk("a_write_expected", qa_addr.size() > 0, 1);
            if (qa_addr.size() > 0) begin
               chk("a_addr", out_addr_a, qa_addr.pop_front());
               chk("a_data", out_data_a, qa_data.pop_front());
            end
         end
         if (done_a) done_cnt_a++;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_b || out_we_b || out_en_b)
            chk("b_we_en_vs_valid", {out_we_b, out_en_b}, {valid_b, valid_b});
         if (valid_b) begin
            wr_cnt_b++;
            obs_b[out_addr_b[7:0]] = out_data_b;
            chk("b_write_expected", qb_addr.size() > 0, 1);
            if (qb_addr.size() > 0) begin
               chk("b_addr", out_addr_b, qb_addr.pop_front());
               chk("b_data", out_data_b, qb_data.pop_front());
            end
         end
         if (done_b) done_cnt_b++;
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_ctl_a"}, {done_a, valid_a, in_en_a, out_we_a, out_en_a}, '0);
      chk({tag, "_addr_a"}, {in_addr_a, out_addr_a}, '0);
      chk({tag, "_data_a"}, out_data_a, '0);
      chk({tag, "_ctl_b"}, {done_b, valid_b, in_en_b, out_we_b, out_en_b}, '0);
      chk({tag, "_addr_b"}, {in_addr_b, out_addr_b}, '0);
   endtask

   task automatic run_job(input int d, input int lat);
      int n;
      logic seen;
      build_exp(d);
      if (d == 0) wr_cnt_a = 0; else wr_cnt_b = 0;
      @(negedge clk);
      set_start(d, 1'b1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < lat + 40) begin
         @(negedge clk);
         set_start(d, 1'b0);
         n++;
         seen = get_done(d);
      end
      chk("done_latency", seen ? n : -1, lat);
      @(negedge clk);
      chk("done_one_cycle", get_done(d), 1'b0);
      chk("write_count", (d == 0) ? wr_cnt_a : wr_cnt_b, exp_writes(d));
      chk("queue_drained", (d == 0) ? qa_addr.size() : qb_addr.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int n, m;
      rst_n = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      #1;
      check_zero("reset");
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Nearest-neighbour upsample of 0..3 on the default geometry.
      for (int i = 0; i < 4; i++) mem_a[i] = i;
      run_job(0, 161);
      chk("nn_oc0_y0_x2", obs_a[2], 1);
      chk("nn_oc0_y1_x1", obs_a[5], 0);
      chk("nn_oc0_y2_x1", obs_a[9], 2);
      chk("nn_oc1_y3_x3", obs_a[31], 3);

      repeat (2) begin
         for (int i = 0; i < 4; i++) mem_a[i] = $urandom;
         run_job(0, 161);
      end

      // Cropped K3 geometry: one pixel gathers -5 and +2 from the two input channels.
      for (int i = 0; i < 256; i++) mem_b[i] = '0;
      mem_b[0] = -32'sd5;
      mem_b[6] = 32'sd2;
      run_job(1, 571);
`ifdef CONV_TRANSPOSE_RELU_EN
      chk("neg_sum_px", obs_b[4], 32'h0);
`else
      chk("neg_sum_px", obs_b[4], 32'hFFFF_FFFD);
`endif

      repeat (2) begin
         for (int i = 0; i < 24; i++) mem_b[i] = $urandom;
         run_job(1, 571);
      end

      // Abort mid-accumulation of the fifth pixel, then rerun the full job.
      for (int i = 0; i < 4; i++) mem_a[i] = i;
      build_exp(0);
      wr_cnt_a = 0;
      done_cnt_a = 0;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      n = 0;
      while (wr_cnt_a < 4 && n < 200) begin @(negedge clk); n++; end
      chk("reached_pixel5", wr_cnt_a, 4);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_zero("midjob_reset");
      qa_addr.delete();
      qa_data.delete();
      repeat (20) @(posedge clk);
      chk("no_done_after_abort", done_cnt_a, 0);
      #2 rst_n = 1'b1;
      run_job(0, 161);

      // start held high across a whole job and its DONE cycle.
      build_exp(0);
      build_exp(0);
      wr_cnt_a = 0;
      done_cnt_a = 0;
      @(negedge clk);
      start_a = 1'b1;
      n = 0;
      while (!done_a && n < 400) begin @(negedge clk); n++; end
      chk("held_first_done", n, 161);
      @(negedge clk);
      @(negedge clk);
      start_a = 1'b0;
      m = 2;
      while (!done_a && m < 400) begin @(negedge clk); m++; end
      chk("held_relaunch_gap", m, 162);
      repeat (30) @(negedge clk);
      chk("held_total_writes", wr_cnt_a, 64);
      chk("held_done_count", done_cnt_a, 2);
      chk("held_queue_drained", qa_addr.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
